// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS controller (Moore FSM + ALU decoder).
// Outputs are combinational decodes of state, hold counter and Instr.
// Optional macro JUMP_LINK_EN enables the JAL (opcode 3) and JR (funct 8) paths.
module mc_control_unit #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned ALUCTL_W = 4
) (
  input  logic                cclk,
  input  logic                rstb,
  input  logic [31:0]         Instr,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          RegDst,
  output logic                IorD,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                ExtOp,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [1:0]          Branch,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                IllegalOp,
  output logic [3:0]          State
);

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Reject unsupported parameterisations at elaboration
  if (ALUCTL_W != 4) begin : g_bad_aluctl_w
    $error("mc_control_unit: ALUCTL_W must be 4");
  end
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mc_control_unit: MEM_LAT must be in 1..15");
  end

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADR    = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_ALU_WB     = 4'd7,
    S_BRANCH     = 4'd8,
    S_ITYPE_EXEC = 4'd9,
    S_ITYPE_WB   = 4'd10,
    S_JUMP       = 4'd11,
`ifdef JUMP_LINK_EN
    S_JAL        = 4'd12,
    S_JR         = 4'd13,
`endif
    S_ILLEGAL    = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_hold;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         r_dec;   // {supported, alu code}
  logic [4:0]         i_dec;   // {ExtOp, alu code}
  logic               unused_instr_bits;

  // R-type funct -> {supported, ALU code}; unsupported defaults to ADD
  function automatic logic [4:0] r_decode(input logic [5:0] fn);
    case (fn)
      6'd32:   return {1'b1, ALU_ADD};
      6'd34:   return {1'b1, ALU_SUB};
      6'd36:   return {1'b1, ALU_AND};
      6'd37:   return {1'b1, ALU_OR};
      6'd38:   return {1'b1, ALU_XOR};
      6'd39:   return {1'b1, ALU_NOR};
      6'd42:   return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

  // I-type opcode -> {ExtOp, ALU code}; logical immediates are zero-extended
  function automatic logic [4:0] i_decode(input logic [5:0] op);
    case (op)
      6'd8:    return {1'b1, ALU_ADD};
      6'd10:   return {1'b1, ALU_SLT};
      6'd12:   return {1'b0, ALU_AND};
      6'd13:   return {1'b0, ALU_OR};
      6'd14:   return {1'b0, ALU_XOR};
      default: return {1'b1, ALU_ADD};
    endcase
  endfunction

  assign opcode            = Instr[31:26];
  assign funct             = Instr[5:0];
  assign r_dec             = r_decode(funct);
  assign i_dec             = i_decode(opcode);
  assign last_hold         = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign unused_instr_bits = ^Instr[25:6];
  assign State             = state_q;

  // State and hold-counter registers
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    MemtoReg   = 2'b00;
    RegDst     = 2'b00;
    IorD       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtOp      = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 2'b00;
    ALUControl = ALUCTL_W'(ALU_ADD);
    IllegalOp  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (last_hold) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        case (opcode)
          6'd0:                        state_d = S_EXECUTE;
          6'd35, 6'd43:                state_d = S_MEM_ADR;
          6'd4, 6'd5:                  state_d = S_BRANCH;
          6'd8, 6'd10, 6'd12, 6'd13,
          6'd14:                       state_d = S_ITYPE_EXEC;
          6'd2:                        state_d = S_JUMP;
`ifdef JUMP_LINK_EN
          6'd3:                        state_d = S_JAL;
`endif
          default:                     state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        state_d = (opcode == 6'd43) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        IorD = 1'b1;
        if (last_hold) state_d = S_MEM_WB;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_MEM_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD = 1'b1;
        if (last_hold) begin
          MemWrite = 1'b1;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALUCTL_W'(r_dec[3:0]);
        if (r_dec[4])            state_d = S_ALU_WB;
`ifdef JUMP_LINK_EN
        else if (funct == 6'd8) state_d = S_JR;
`endif
        else                     state_d = S_ILLEGAL;
      end
      S_ALU_WB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALUCTL_W'(ALU_SUB);
        PCSrc      = 2'b01;
        ExtOp      = 1'b1;
        Branch     = (opcode == 6'd5) ? 2'b10 : 2'b01;
        state_d    = S_FETCH;
      end
      S_ITYPE_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ExtOp      = i_dec[4];
        ALUControl = ALUCTL_W'(i_dec[3:0]);
        state_d    = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        ExtOp      = i_dec[4];
        ALUControl = ALUCTL_W'(i_dec[3:0]);
        RegWrite   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
`ifdef JUMP_LINK_EN
      S_JAL: begin
        PCSrc    = 2'b10;
        PCWrite  = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        PCSrc   = 2'b11;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: begin
        IllegalOp = 1'b1;
        state_d   = S_FETCH;
      end
    endcase
  end

endmodule
